// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-host device-bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick_2.sv
// Two-way round-robin selector: on a tie the host that did not win last time is chosen.
module rr_pick_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_2.sv
// Round-robin arbiter sharing one device bus between two hosts, with a per-transaction
// watchdog that force-completes a transfer the device never acknowledges.
module bus_arbiter_2
  import bus_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] h0_address,
  input  logic [31:0] h1_address,
  input  logic [31:0] h0_data_write,
  input  logic [31:0] h1_data_write,
  input  logic [3:0]  h0_write_mask,
  input  logic [3:0]  h1_write_mask,
  input  logic        h0_ren,
  input  logic        h1_ren,
  input  logic        h0_wen,
  input  logic        h1_wen,
  output logic [31:0] h0_data_read,
  output logic [31:0] h1_data_read,
  output logic        h0_ready,
  output logic        h1_ready,
  output logic [31:0] dev_address,
  output logic [31:0] dev_data_write,
  output logic [3:0]  dev_write_mask,
  output logic        dev_ren,
  output logic        dev_wen,
  input  logic [31:0] dev_data_read,
  input  logic        dev_ready,
  output logic [1:0]  grant,
  output logic        timeout_err,
  output logic        err_host,
  input  logic        err_clear
);

  // Width 1 is kept for the disabled watchdog so the counter is never zero-width.
  localparam int               CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               WD_EN = (TIMEOUT_CYCLES != 0);

  state_t           state;
  state_t           state_next;
  logic [1:0]       owner_oh;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] wd_cnt;

  logic [1:0]       req;
  logic [1:0]       pick_gnt;
  logic             arbitrate;
  logic             wd_hit;
  logic             expire;
  logic             done;

  logic [31:0]      own_address;
  logic [31:0]      own_data_write;
  logic [3:0]       own_write_mask;
  logic             own_ren;
  logic             own_wen;
  logic [31:0]      ret_data;

  assign req       = {h1_ren | h1_wen, h0_ren | h0_wen};
  assign arbitrate = (state == IDLE) && (req != 2'b00);
  assign owner     = owner_oh[1];

  rr_pick_2 u_pick (
    .req  (req),
    .last (last_grant),
    .gnt  (pick_gnt)
  );

  assign own_address    = owner ? h1_address    : h0_address;
  assign own_data_write = owner ? h1_data_write : h0_data_write;
  assign own_write_mask = owner ? h1_write_mask : h0_write_mask;
  assign own_ren        = owner ? h1_ren        : h0_ren;
  assign own_wen        = owner ? h1_wen        : h0_wen;

  // A device ready arriving on the expiry cycle is a normal completion, not an error.
  assign wd_hit   = WD_EN && (state == BUSY) && (wd_cnt == LIMIT);
  assign expire   = wd_hit && !dev_ready;
  assign done     = (state == BUSY) && (dev_ready || wd_hit);
  assign ret_data = expire ? ERR_RDATA : dev_data_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req != 2'b00) state_next = BUSY;
      BUSY:    if (dev_ready || wd_hit) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Owner and round-robin history only move when a new transaction is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_oh   <= 2'b00;
      last_grant <= 1'b1;
    end else if (arbitrate) begin
      owner_oh   <= pick_gnt;
      last_grant <= pick_gnt[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (arbitrate) begin
      wd_cnt <= '0;
    end else if (WD_EN && state == BUSY && !done) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // A fresh expiry takes precedence over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
      err_host    <= 1'b0;
    end else if (expire) begin
      timeout_err <= 1'b1;
      err_host    <= owner;
    end else if (err_clear) begin
      timeout_err <= 1'b0;
    end
  end

  // Everything outside BUSY is quiet, so an asynchronous reset drops the bus at once.
  always_comb begin
    dev_address    = '0;
    dev_data_write = '0;
    dev_write_mask = '0;
    dev_ren        = 1'b0;
    dev_wen        = 1'b0;
    h0_ready       = 1'b0;
    h1_ready       = 1'b0;
    h0_data_read   = '0;
    h1_data_read   = '0;
    grant          = 2'b00;
    if (state == BUSY) begin
      dev_address    = own_address;
      dev_data_write = own_data_write;
      dev_write_mask = own_write_mask;
      dev_wen        = own_wen && !expire;
      dev_ren        = own_ren && !own_wen && !expire;
      if (owner) begin
        h1_ready     = done;
        h1_data_read = ret_data;
      end else begin
        h0_ready     = done;
        h0_data_read = ret_data;
      end
    end
    if (state != IDLE) begin
      grant = owner_oh;
    end
  end

endmodule
